spike_event_packer: RTL and testbench

Buffers motoneuron spike events for host readout. It sits between the neuron pool's spike outputs (spike strobe plus spike id) and the block-throttled pipe-out endpoint. Each spike becomes a tagged 16-bit word, and each simulation tick inserts a frame-marker word. Words are held in a first-word-fall-through FIFO, and `block_ready` asserts only when a full transfer block is available.

---
 rtl/spike_pkg.sv | 26 ++
 rtl/spike_fifo_ram.sv | 26 ++
 rtl/spike_event_packer.sv | 169 ++++++++++++++++
 tb/tb_spike_event_packer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Word formats and constants shared by the spike packer and the host-side decoder.
package spike_pkg;

    localparam int          WORD_W     = 16;
    localparam int          MARKER_BIT = 15;
    localparam int          SPKID_W    = 15;
    localparam logic [15:0] DROP_SAT   = 16'hFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } wr_state_t;

    // Bit 15 of the neuron id is forced to zero so spike words never look like markers.
    function automatic logic [WORD_W-1:0] mk_spike_word(input logic [WORD_W-1:0] id);
        logic [WORD_W-1:0] w;
        w             = id;
        w[MARKER_BIT] = 1'b0;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] mk_marker_word(input logic [SPKID_W-1:0] frame);
        return {1'b1, frame};
    endfunction

endpackage

// File: rtl/spike_fifo_ram.sv
// Simple dual-port RAM with registered read; the read returns the pre-write contents.
module spike_fifo_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spike_event_packer.sv
// Packs spike strobes and simulation ticks into tagged words and buffers them in a
// first-word-fall-through FIFO for block-throttled host readout.
module spike_event_packer
    import spike_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spike,
    input  logic [15:0]           spkid,
    input  logic                  sim_tick,
    input  logic                  rd_en,
    output logic [15:0]           dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  block_ready,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           drop_cnt
);

    localparam int              AW          = DEPTH_LOG2;
    localparam int              CW          = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   FULL_COUNT  = CW'(2 ** DEPTH_LOG2);
    localparam logic [31:0]     BLOCK_THR   = BLOCK_WORDS;

    wr_state_t           state_q, state_d;
    logic [WORD_W-1:0]   pend_word_q, pend_word_d;
    logic [SPKID_W-1:0]  frame_q, frame_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                block_ready_q, block_ready_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                wr_req;
    logic [WORD_W-1:0]   wr_word;
    logic [1:0]          evt_drop;
    logic                pop;
    logic                wr_ok;
    logic [1:0]          n_drop;
    logic [16:0]         drop_sum;
    logic [WORD_W-1:0]   ram_rdata;

    // Write-port arbitration: a held word always goes first; a tick that arrives
    // behind it takes its place in the holding register instead of being lost.
    always_comb begin
        state_d     = state_q;
        pend_word_d = pend_word_q;
        frame_d     = frame_q;
        wr_req      = 1'b0;
        wr_word     = '0;
        evt_drop    = 2'd0;

        if (sim_tick) begin
            frame_d = frame_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sim_tick) begin
                    wr_req  = 1'b1;
                    wr_word = mk_marker_word(frame_q);
                    if (spike) begin
                        state_d     = ST_PEND;
                        pend_word_d = mk_spike_word(spkid);
                    end
                end else if (spike) begin
                    wr_req  = 1'b1;
                    wr_word = mk_spike_word(spkid);
                end
            end
            ST_PEND: begin
                wr_req  = 1'b1;
                wr_word = pend_word_q;
                state_d = ST_IDLE;
                if (sim_tick) begin
                    state_d     = ST_PEND;
                    pend_word_d = mk_marker_word(frame_q);
                end
                if (spike) begin
                    evt_drop = 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The RAM always reads the address that will be the head after this edge, so the
    // head register is refreshed every cycle; a word becomes visible one cycle after
    // it was committed to the RAM.
    always_comb begin
        pop           = rd_en & ~empty_q;
        wr_ok         = wr_req & (~full_q | pop);
        n_drop        = evt_drop + 2'(wr_req & ~wr_ok);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        wr_ptr_d      = wr_ptr_q + AW'(wr_ok);
        count_d       = count_q + CW'(wr_ok) - CW'(pop);
        empty_d       = (count_q == CW'(pop));
        full_d        = (count_d == FULL_COUNT);
        block_ready_d = (32'(count_d) >= BLOCK_THR);
        overflow_d    = overflow_q | (n_drop != 2'd0);
        underflow_d   = underflow_q | (rd_en & empty_q);
        drop_sum      = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d    = (drop_sum > {1'b0, DROP_SAT}) ? DROP_SAT : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pend_word_q   <= '0;
            frame_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            block_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_word_q   <= pend_word_d;
            frame_q       <= frame_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            block_ready_q <= block_ready_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    spike_fifo_ram #(
        .ADDR_W (AW),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & reset_n),
        .waddr (wr_ptr_q),
        .wdata (wr_word),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    // Masking keeps stale RAM data off the bus whenever no head word is valid.
    assign dout        = empty_q ? '0 : ram_rdata;
    assign empty       = empty_q;
    assign full        = full_q;
    assign count       = count_q;
    assign block_ready = block_ready_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_spike_event_packer.sv
// Randomized and directed bench for spike_event_packer against a queue-based reference model.
module tb_spike_event_packer;

    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;
    localparam int BLOCK = 256;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spike = 1'b0;
    logic [15:0]   spkid = '0;
    logic          sim_tick = 1'b0;
    logic          rd_en = 1'b0;
    logic [15:0]   dout;
    logic          empty;
    logic          full;
    logic [DL2:0]  count;
    logic          block_ready;
    logic          overflow;
    logic          underflow;
    logic [15:0]   drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    spike_event_packer #(
        .DEPTH_LOG2  (DL2),
        .BLOCK_WORDS (BLOCK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spike       (spike),
        .spkid       (spkid),
        .sim_tick    (sim_tick),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .block_ready (block_ready),
        .overflow    (overflow),
        .underflow   (underflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: logical word queue tagged with the edge each word was committed.
    typedef struct {
        logic [15:0] w;
        int          c;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mpend[$];
    logic [14:0] mframe = '0;
    int          mdrop = 0;
    bit          movf = 1'b0;
    bit          mudf = 1'b0;
    bit          mempty = 1'b1;
    int          edge_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit sp, input logic [15:0] id, input bit tk,
                              input bit rd, input bit rst_n);
        bit          pop;
        bit          has;
        logic [15:0] cand;
        int          drops;
        ent_t        e;
        edge_n++;
        if (!rst_n) begin
            mq.delete();
            mpend.delete();
            mframe = '0;
            mdrop  = 0;
            movf   = 1'b0;
            mudf   = 1'b0;
            mempty = 1'b1;
            return;
        end
        pop = rd && !mempty;
        if (rd && mempty) mudf = 1'b1;
        has   = 1'b0;
        drops = 0;
        cand  = '0;
        if (mpend.size() > 0) begin
            cand = mpend.pop_front();
            has  = 1'b1;
            if (tk) mpend.push_back({1'b1, mframe});
            if (sp) drops++;
        end else if (tk) begin
            cand = {1'b1, mframe};
            has  = 1'b1;
            if (sp) mpend.push_back({1'b0, id[14:0]});
        end else if (sp) begin
            cand = {1'b0, id[14:0]};
            has  = 1'b1;
        end
        if (tk) mframe = mframe + 15'd1;
        if (has && mq.size() >= DEPTH && !pop) begin
            drops++;
            has = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (has) begin
            e.w = cand;
            e.c = edge_n;
            mq.push_back(e);
        end
        mdrop = (mdrop + drops > 65535) ? 65535 : mdrop + drops;
        if (drops > 0) movf = 1'b1;
        mempty = (mq.size() == 0) || (mq[0].c >= edge_n);
    endtask

    task automatic compare_all();
        int sz;
        sz = mq.size();
        chk("count",       32'(count),       sz);
        chk("full",        32'(full),        32'(sz == DEPTH));
        chk("block_ready", 32'(block_ready), 32'(sz >= BLOCK));
        chk("empty",       32'(empty),       32'(mempty));
        chk("dout",        32'(dout),        mempty ? 32'd0 : 32'(mq[0].w));
        chk("overflow",    32'(overflow),    32'(movf));
        chk("underflow",   32'(underflow),   32'(mudf));
        chk("drop_cnt",    32'(drop_cnt),    mdrop);
    endtask

    task automatic cyc(input bit sp, input logic [15:0] id, input bit tk,
                       input bit rd, input bit rst_n);
        spike    = sp;
        spkid    = id;
        sim_tick = tk;
        rd_en    = rd;
        reset_n  = rst_n;
        @(posedge clk);
        model_step(sp, id, tk, rd, rst_n);
        #1;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 2*DEPTH + 8 && (count != 0 || !empty); i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        end
        chk("drain_count", 32'(count), 32'd0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] basic_exp [4];
        basic_exp[0] = 16'h0005;
        basic_exp[1] = 16'h0006;
        basic_exp[2] = 16'h0007;
        basic_exp[3] = 16'h8000;

        do_reset();
        do_reset();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout",  32'(dout),  32'd0);
        $display("reset: count=%0d empty=%0d", count, empty);

        // Basic order
        cyc(1'b1, 16'd5, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'd6, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        chk("basic_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_dout", 32'(dout), 32'(basic_exp[i]));
            cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        end
        chk("basic_empty", 32'(empty), 32'd1);
        $display("basic order: count=%0d empty=%0d", count, empty);

        // Two more markers so the collision sees frame 3
        cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
        drain();
        cyc(1'b1, 16'h0012, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("coll_first", 32'(dout), 32'h8003);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("coll_second", 32'(dout), 32'h0012);
        chk("coll_drop", 32'(drop_cnt), 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        $display("collision: drop_cnt=%0d", drop_cnt);

        // Pending conflict
        cyc(1'b1, 16'h0012, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1);
        chk("pend_drop", 32'(drop_cnt), 32'd1);
        chk("pend_ovf",  32'(overflow), 32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("pend_count", 32'(count), 32'd2);
        drain();
        $display("pending conflict: drop_cnt=%0d overflow=%0d", drop_cnt, overflow);

        // Underflow, then reset with words queued
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("udf_set", 32'(underflow), 32'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        do_reset();
        chk("rst2_count", 32'(count),     32'd0);
        chk("rst2_empty", 32'(empty),     32'd1);
        chk("rst2_dout",  32'(dout),      32'd0);
        chk("rst2_udf",   32'(underflow), 32'd0);
        chk("rst2_ovf",   32'(overflow),  32'd0);
        chk("rst2_drop",  32'(drop_cnt),  32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            chk("rst2_stale", 32'(dout), 32'd0);
        end
        $display("reset mid-run: count=%0d empty=%0d", count, empty);

        // Block threshold and full
        for (int i = 0; i < BLOCK - 1; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
        chk("blk_below", 32'(block_ready), 32'd0);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1);
        chk("blk_at", 32'(block_ready), 32'd1);
        for (int i = BLOCK; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
        chk("full_set",   32'(full),  32'd1);
        chk("full_count", 32'(count), 32'(DEPTH));
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        chk("full_drop", 32'(drop_cnt), 32'd1);
        cyc(1'b1, 16'h1235, 1'b0, 1'b1, 1'b1);
        chk("full_rdwr_count", 32'(count),    32'(DEPTH));
        chk("full_rdwr_drop",  32'(drop_cnt), 32'd1);
        $display("full: count=%0d drop_cnt=%0d", count, drop_cnt);
        do_reset();

        // Frame counter wrap
        for (int i = 0; i < 32'h7FFF; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        drain();
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("wrap_last", 32'(dout), 32'hFFFF);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("wrap_first", 32'(dout), 32'h8000);
        $display("frame wrap: dout=0x%0h", dout);
        do_reset();

        // Randomized traffic: fill-heavy phase then drain-heavy phase with rare resets
        for (int i = 0; i < 3500; i++) begin
            int  ps;
            int  pr;
            bit  rst_n;
            ps    = (i < 2000) ? 75 : 25;
            pr    = (i < 2000) ? 5 : 85;
            rst_n = (i < 2000) ? 1'b1 : ($urandom_range(999) != 0);
            cyc($urandom_range(99) < ps, 16'($urandom), $urandom_range(99) < 15,
                $urandom_range(99) < pr, rst_n);
        end
        $display("random: count=%0d drop_cnt=%0d overflow=%0d", count, drop_cnt, overflow);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
